// File: rtl/demux_pkg.sv
// Shared constants and the channel-select type for the 1:8 channel demultiplexer.
package demux_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One output channel: a one-deep word register with a valid flag, loaded from the
// shared input bus and emptied by its own consumer.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         ready,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] data,
    output logic         valid
);

    // A load in the same cycle as a drain replaces the word and keeps valid set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_8_chan.sv
// Routes one W-bit word stream to eight one-deep channels with per-channel backpressure.
// Build option: define AUTO_SEL_EN for strict round-robin channel selection (in_sel ignored).
module demux_1_8_chan
    import demux_pkg::*;
#(
    parameter int W     = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*W-1:0]     out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [2:0]         cur_sel,
    output logic [CNT_W-1:0]   acc_cnt
);

    sel_t           sel;
    logic           accept;
    logic [NCH-1:0] load_vec;

`ifdef AUTO_SEL_EN
    sel_t slot_ptr;
    logic unused_in_sel;

    assign unused_in_sel = ^in_sel;

    // Round-robin pointer only moves on an accept, so a full slot stalls the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ptr <= '0;
        end else if (accept) begin
            slot_ptr <= slot_ptr + sel_t'(1);
        end
    end

    assign sel = slot_ptr;
`else
    assign sel = in_sel;
`endif

    assign cur_sel  = sel;
    assign in_ready = ~out_valid[sel] | out_ready[sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load_vec      = '0;
        load_vec[sel] = accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[i]),
            .ready     (out_ready[i]),
            .load_data (in_data),
            .data      (out_data[i*W +: W]),
            .valid     (out_valid[i])
        );
    end

endmodule

// File: tb/tb_demux_1_8_chan.sv
// Scoreboard bench for demux_1_8_chan: per-channel expected-word queues fed on accept, drained on consumer take.
module tb_demux_1_8_chan;
`ifdef AUTO_SEL_EN
    localparam int W = 4;
`else
    localparam int W = 3;
`endif
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_data;
    logic [2:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [8*W-1:0]   out_data;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [2:0]       cur_sel;
    logic [CNT_W-1:0] acc_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] exp_q [8][$];
    logic [2:0]   model_ptr;

    always #5 clk = ~clk;

    demux_1_8_chan #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cur_sel   (cur_sel),
        .acc_cnt   (acc_cnt)
    );

    // Scoreboard: sampled mid-cycle, ahead of the edge that acts on these values.
    always @(negedge clk) begin
        if (!rst) begin
            logic [2:0] c;
            logic       exp_rdy;
`ifdef AUTO_SEL_EN
            c = model_ptr;
`else
            c = in_sel;
`endif
            exp_rdy = (exp_q[c].size() == 0) || out_ready[c];
            chk_cnt++;
            if (in_ready !== exp_rdy)
                $display("FAIL sb_in_ready sel=%0d got=%b exp=%b", c, in_ready, exp_rdy);
            else
                pass_cnt++;
            for (int i = 0; i < 8; i++) begin
                chk_cnt++;
                if (out_valid[i] !== (exp_q[i].size() != 0))
                    $display("FAIL sb_valid ch%0d got=%b exp=%b", i, out_valid[i], exp_q[i].size() != 0);
                else
                    pass_cnt++;
                if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
                    chk_cnt++;
                    if (out_data[i*W +: W] !== exp_q[i][0])
                        $display("FAIL sb_data ch%0d got=%0h exp=%0h", i, out_data[i*W +: W], exp_q[i][0]);
                    else
                        pass_cnt++;
                    void'(exp_q[i].pop_front());
                end
            end
            if (in_valid && exp_rdy) begin
                exp_q[c].push_back(in_data);
                model_ptr = model_ptr + 3'd1;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 8; i++) exp_q[i].delete();
        model_ptr = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        clear_model();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] s, input logic [W-1:0] d);
        int n = 0;
        in_sel = s; in_data = d; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            chk_cnt++;
            $display("FAIL send_timeout sel=%0d got=in_ready_low exp=in_ready_high", s);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = 8'h00;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (out_valid !== 8'h00) $display("FAIL reset_valid got=%h exp=00", out_valid); else pass_cnt++;
        chk_cnt++;
        if (out_data !== '0) $display("FAIL reset_data got=%h exp=0", out_data); else pass_cnt++;
        chk_cnt++;
        if (acc_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", acc_cnt); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_basic_route();
        do_reset();
        out_ready = 8'hFF;
        send(3'd3, 3'b101);
        chk_cnt++;
        if (out_valid !== 8'h08) $display("FAIL route_valid got=%h exp=08", out_valid); else pass_cnt++;
        chk_cnt++;
        if (out_data[11:9] !== 3'b101) $display("FAIL route_data got=%b exp=101", out_data[11:9]); else pass_cnt++;
        chk_cnt++;
        if (acc_cnt !== 4'd1) $display("FAIL route_cnt got=%0d exp=1", acc_cnt); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 8'h00) $display("FAIL route_drain got=%h exp=00", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 8'hBF;
        send(3'd6, 3'b010);
        in_sel = 3'd6; in_data = 3'b111; in_valid = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_stall got=%b exp=0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_data[20:18] !== 3'b010 || acc_cnt !== 4'd1)
            $display("FAIL bp_hold got=%b/%0d exp=010/1", out_data[20:18], acc_cnt);
        else pass_cnt++;
        out_ready[6] = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_cnt++;
        if (out_valid[6] !== 1'b1 || out_data[20:18] !== 3'b111 || acc_cnt !== 4'd2)
            $display("FAIL bp_replace got=%b/%b/%0d exp=1/111/2", out_valid[6], out_data[20:18], acc_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_parallel_drain();
        do_reset();
        out_ready = 8'h00;
        for (int i = 0; i < 8; i++) send(3'(i), W'(i));
        chk_cnt++;
        if (out_valid !== 8'hFF || acc_cnt !== 4'd8)
            $display("FAIL fill got=%h/%0d exp=ff/8", out_valid, acc_cnt);
        else pass_cnt++;
        out_ready = 8'hFF;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 8'h00 || acc_cnt !== 4'd8)
            $display("FAIL par_drain got=%h/%0d exp=00/8", out_valid, acc_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (out_data[5*W +: W] !== W'(5)) $display("FAIL drain_hold got=%0d exp=5", out_data[5*W +: W]); else pass_cnt++;
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        out_ready = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_sel = 3'(i); in_data = W'(i);
            #1;
            chk_cnt++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready word%0d got=%b exp=1", i, in_ready); else pass_cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (acc_cnt !== 4'd1) $display("FAIL cnt_wrap got=%0d exp=1", acc_cnt); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        out_ready = 8'h00;
        send(3'd2, W'(3));
        send(3'd5, W'(6));
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (out_valid !== 8'h00 || out_data !== '0 || acc_cnt !== '0)
            $display("FAIL mid_reset got=%h/%h/%0d exp=00/0/0", out_valid, out_data, acc_cnt);
        else pass_cnt++;
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef AUTO_SEL_EN
    task automatic test_auto_sel();
        do_reset();
        out_ready = 8'hFF;
        in_valid = 1'b1;
        in_sel = 3'd5;
        for (int i = 0; i < 10; i++) begin
            in_data = W'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (out_data[0 +: W] !== W'(8) || out_data[W +: W] !== W'(9) || acc_cnt !== 4'd10)
            $display("FAIL auto_rr got=%0d/%0d/%0d exp=8/9/10", out_data[0 +: W], out_data[W +: W], acc_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_SEL_EN
        test_auto_sel();
`else
        test_basic_route();
        test_backpressure();
        test_parallel_drain();
        test_back_to_back_wrap();
`endif
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
